mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multi-cycle datapath between two requesters: the instruction-fetch path (I) and the load/store path (D).
- Sequences every memory transaction: grant, a registered request to memory, a wait for MemReady, then return of read data with a one-cycle Done pulse.
- Data accesses have priority. A bounded starvation counter guarantees that fetch is still served.
- Sits between the CPU control/datapath and the memory model.

Parameters:
- DataSize, 32, data bus width
- AddrSize, 32, address width
- MaxWait, 4, consecutive data grants allowed while a fetch is pending; the next grant then goes to fetch

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high reset
- IReq  input  1  fetch request; held until IDone
- IAddr  input  AddrSize  fetch address
- IDone  output  1  one-cycle pulse: fetch complete
- IRData  output  DataSize  fetched word, valid from IDone onward
- DReq  input  1  data request; held until DDone
- DWe  input  1  1 = store, 0 = load
- DAddr  input  AddrSize  data address
- DWData  input  DataSize  store data
- DDone  output  1  one-cycle pulse: data access complete
- DRData  output  DataSize  load data, valid from DDone onward
- MemReq  output  1  memory request, registered
- MemWe  output  1  memory write enable
- MemAddr  output  AddrSize  memory address
- MemWData  output  DataSize  memory write data
- MemRData  input  DataSize  memory read data, valid when MemReady=1
- MemReady  input  1  memory completes the current access
- ArbState  output  2  0 IDLE, 1 IFETCH, 2 DACCESS

Behaviour:
- Reset is synchronous and active-high. On Reset, all outputs go to 0 at the next edge: state IDLE, StarveCnt 0, MemReq/MemWe/IDone/DDone 0, MemAddr/MemWData/IRData/DRData 0. Reset overrides any access in flight; the transaction is abandoned, with no Done pulse.
- Effective requests: IEff = IReq & ~IDone, DEff = DReq & ~DDone. Masking prevents a re-grant in the cycle a requester is still seeing its own Done.
- IDLE:
  - Neither request effective: stay in IDLE.
  - DEff only: go to DACCESS.
  - IEff only: go to IFETCH.
  - Both effective: go to IFETCH if StarveCnt == MaxWait, otherwise DACCESS.
- At the grant edge:
  - MemReq <= 1.
  - MemAddr <= granted address.
  - MemWe <= DWe for a data grant, 0 for a fetch grant.
  - MemWData <= DWData for a data grant, held otherwise.
  - These values stay frozen until completion, even if the requester's inputs change.
- StarveCnt update:
  - On a data grant with IEff=1: StarveCnt <= StarveCnt+1, saturating at MaxWait.
  - On a fetch grant: StarveCnt <= 0.
  - Otherwise: held.
  - Width is clog2(MaxWait+1), minimum 1 bit.
  - MaxWait=0 makes fetch always win a tie.
- IFETCH / DACCESS:
  - Wait while MemReady=0; there is no timeout.
  - At the edge where MemReady=1: IRData or DRData <= MemRData (loads and fetches only; DRData is held on stores). Also the matching Done <= 1, MemReq <= 0, MemWe <= 0, state <= IDLE.
- Done lasts exactly one cycle and is cleared at the next edge.
- A requester dropping Req mid-access does not abort the access; Done still pulses.
- MemReady while MemReq=0 is ignored.
- Latency: a request sampled at edge N gives MemReq high after N. With MemReady=1 in that first cycle, Done is high after N+1. Minimum occupancy is 2 cycles per access plus 1 IDLE cycle between accesses.

Decomposition:
- Shared package holds:
  - ARB_IDLE/ARB_IFETCH/ARB_DACCESS state constants (2-bit)
  - ArbState width
- One sub-module is natural: mem_arb_select. It is combinational winner select (IEff, DEff, StarveCnt, MaxWait -> grant_i, grant_d). It is unit-testable on its own.
- The StarveCnt register stays in the parent.

Test Plan:
1. Reset, then IReq=1, IAddr=0x00000040, MemReady high on the 2nd MemReq cycle with MemRData=0x8C220004 -> MemReq=1, MemAddr=0x40, MemWe=0; IDone pulses 1 cycle after MemReady; IRData=0x8C220004; ArbState goes 1 then 0.
2. IReq (IAddr 0x44) and DReq store (DAddr 0x1000, DWData 0xDEADBEEF) in the same cycle, MemReady always 1 -> data is served first with MemWe=1, MemAddr=0x1000, MemWData=0xDEADBEEF; DDone pulses; then fetch of 0x44; DRData unchanged.
3. MaxWait=4, DReq and IReq held continuously (each re-raised after its Done) -> grant sequence D,D,D,D,I; StarveCnt goes 0..4 then 0.
4. The requester keeps IReq high during the IDone cycle and drops it afterwards -> exactly one MemReq transaction; ArbState stays 0.
5. Reset asserted during DACCESS with MemReady=0 -> next cycle MemReq=0, ArbState=0, DDone=0, DRData=0; no Done pulse ever appears.
6. DReq load dropped after the grant, MemReady after 3 cycles with MemRData=0x12345678 -> DDone still pulses and DRData=0x12345678.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: state encoding,
// state width and the starvation-counter width helper.
package mem_port_arbiter_pkg;

    localparam int ARB_STATE_W = 2;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IFETCH  = 2'd1,
        ARB_DACCESS = 2'd2
    } arb_state_t;

    // Counter must hold 0..max_wait; never narrower than one bit.
    function automatic int starve_cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// The arbiter uses the slave view; the CPU/memory environment uses master.
interface mem_port_arbiter_if #(
    parameter int DataSize = 32,
    parameter int AddrSize = 32
);
    import mem_port_arbiter_pkg::*;

    logic                   IReq;
    logic [AddrSize-1:0]    IAddr;
    logic                   IDone;
    logic [DataSize-1:0]    IRData;
    logic                   DReq;
    logic                   DWe;
    logic [AddrSize-1:0]    DAddr;
    logic [DataSize-1:0]    DWData;
    logic                   DDone;
    logic [DataSize-1:0]    DRData;
    logic                   MemReq;
    logic                   MemWe;
    logic [AddrSize-1:0]    MemAddr;
    logic [DataSize-1:0]    MemWData;
    logic [DataSize-1:0]    MemRData;
    logic                   MemReady;
    logic [ARB_STATE_W-1:0] ArbState;

    modport slave (
        input  IReq, IAddr, DReq, DWe, DAddr, DWData, MemRData, MemReady,
        output IDone, IRData, DDone, DRData, MemReq, MemWe, MemAddr, MemWData, ArbState
    );

    modport master (
        output IReq, IAddr, DReq, DWe, DAddr, DWData, MemRData, MemReady,
        input  IDone, IRData, DDone, DRData, MemReq, MemWe, MemAddr, MemWData, ArbState
    );

endinterface

// File: rtl/mem_arb_select.sv
// Combinational winner select: data wins ties unless fetch has already been
// passed over MaxWait times, in which case fetch wins.
module mem_arb_select #(
    parameter int MaxWait = 4,
    parameter int CntW    = 3
) (
    input  logic            i_eff,
    input  logic            d_eff,
    input  logic [CntW-1:0] starve_cnt,
    output logic            grant_i,
    output logic            grant_d
);

    localparam logic [CntW-1:0] MAX_CNT = CntW'(MaxWait);

    logic starved;

    // Fetch takes the port when alone or when it has waited long enough.
    always_comb begin
        starved = (starve_cnt == MAX_CNT);
        grant_i = i_eff & (~d_eff | starved);
        grant_d = d_eff & ~grant_i;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and load/store.
// Each access: grant with registered request, wait for MemReady, then return
// read data with a one-cycle Done pulse and one IDLE cycle before the next.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DataSize = 32,
    parameter int AddrSize = 32,
    parameter int MaxWait  = 4
) (
    input logic               Clk,
    input logic               Reset,
    mem_port_arbiter_if.slave bus
);

    localparam int CntW = starve_cnt_width(MaxWait);
    localparam logic [CntW-1:0] MAX_CNT = CntW'(MaxWait);

    arb_state_t          state_reg, state_next;
    logic [CntW-1:0]     starve_cnt_reg, starve_cnt_next;
    logic                mem_req_reg, mem_req_next;
    logic                mem_we_reg, mem_we_next;
    logic [AddrSize-1:0] mem_addr_reg, mem_addr_next;
    logic [DataSize-1:0] mem_wdata_reg, mem_wdata_next;
    logic                i_done_reg, i_done_next;
    logic                d_done_reg, d_done_next;
    logic [DataSize-1:0] i_rdata_reg, i_rdata_next;
    logic [DataSize-1:0] d_rdata_reg, d_rdata_next;

    logic i_eff;
    logic d_eff;
    logic grant_i;
    logic grant_d;

    // A requester still seeing its own Done must not be granted again.
    assign i_eff = bus.IReq & ~i_done_reg;
    assign d_eff = bus.DReq & ~d_done_reg;

    mem_arb_select #(
        .MaxWait (MaxWait),
        .CntW    (CntW)
    ) u_select (
        .i_eff      (i_eff),
        .d_eff      (d_eff),
        .starve_cnt (starve_cnt_reg),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    // Next-state and datapath: grant from IDLE, complete on MemReady.
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        i_done_next     = 1'b0;
        d_done_next     = 1'b0;
        i_rdata_next    = i_rdata_reg;
        d_rdata_next    = d_rdata_reg;

        case (state_reg)
            ARB_IDLE: begin
                if (grant_i) begin
                    state_next      = ARB_IFETCH;
                    mem_req_next    = 1'b1;
                    mem_we_next     = 1'b0;
                    mem_addr_next   = bus.IAddr;
                    starve_cnt_next = '0;
                end else if (grant_d) begin
                    state_next     = ARB_DACCESS;
                    mem_req_next   = 1'b1;
                    mem_we_next    = bus.DWe;
                    mem_addr_next  = bus.DAddr;
                    mem_wdata_next = bus.DWData;
                    // Count data grants that overtook a waiting fetch.
                    if (i_eff && (starve_cnt_reg != MAX_CNT)) begin
                        starve_cnt_next = starve_cnt_reg + CntW'(1);
                    end
                end
            end
            ARB_IFETCH: begin
                if (bus.MemReady) begin
                    state_next   = ARB_IDLE;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    i_rdata_next = bus.MemRData;
                    i_done_next  = 1'b1;
                end
            end
            ARB_DACCESS: begin
                if (bus.MemReady) begin
                    state_next   = ARB_IDLE;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    // Stores leave the previous load data visible.
                    if (!mem_we_reg) begin
                        d_rdata_next = bus.MemRData;
                    end
                    d_done_next = 1'b1;
                end
            end
            default: begin
                state_next   = ARB_IDLE;
                mem_req_next = 1'b0;
                mem_we_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= ARB_IDLE;
            starve_cnt_reg <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            i_done_reg     <= 1'b0;
            d_done_reg     <= 1'b0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            i_done_reg     <= i_done_next;
            d_done_reg     <= d_done_next;
            i_rdata_reg    <= i_rdata_next;
            d_rdata_reg    <= d_rdata_next;
        end
    end

    assign bus.MemReq   = mem_req_reg;
    assign bus.MemWe    = mem_we_reg;
    assign bus.MemAddr  = mem_addr_reg;
    assign bus.MemWData = mem_wdata_reg;
    assign bus.IDone    = i_done_reg;
    assign bus.DDone    = d_done_reg;
    assign bus.IRData   = i_rdata_reg;
    assign bus.DRData   = d_rdata_reg;
    assign bus.ArbState = state_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-rule reference model.
module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter_if #(.DataSize(DW), .AddrSize(AW)) bus ();

    mem_port_arbiter #(
        .DataSize (DW),
        .AddrSize (AW),
        .MaxWait  (MAXW)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IReq     = 1'b0;
        bus.IAddr    = '0;
        bus.DReq     = 1'b0;
        bus.DWe      = 1'b0;
        bus.DAddr    = '0;
        bus.DWData   = '0;
        bus.MemRData = '0;
        bus.MemReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.MemReady = 1'b1;
        tick();
        tick();
        vectors++; if (bus.MemReq !== 1'b0) begin miscompares++; $display("FAIL reset_memreq: got %0h want 0", bus.MemReq); end
        vectors++; if (bus.MemWe !== 1'b0) begin miscompares++; $display("FAIL reset_memwe: got %0h want 0", bus.MemWe); end
        vectors++; if (bus.IDone !== 1'b0 || bus.DDone !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0h/%0h want 0/0", bus.IDone, bus.DDone); end
        vectors++; if (bus.MemAddr !== 32'h0 || bus.MemWData !== 32'h0) begin miscompares++; $display("FAIL reset_membus: got %0h/%0h want 0/0", bus.MemAddr, bus.MemWData); end
        vectors++; if (bus.IRData !== 32'h0 || bus.DRData !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %0h/%0h want 0/0", bus.IRData, bus.DRData); end
        vectors++; if (bus.ArbState !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", bus.ArbState); end
        reset = 1'b0;
        bus.MemReady = 1'b0;
        tick();
        $display("txn reset done");
    endtask

    task automatic test_fetch();
        bus.IReq  = 1'b1;
        bus.IAddr = 32'h0000_0040;
        tick();
        vectors++; if (bus.MemReq !== 1'b1 || bus.MemWe !== 1'b0) begin miscompares++; $display("FAIL fetch_grant: req/we got %0h/%0h want 1/0", bus.MemReq, bus.MemWe); end
        vectors++; if (bus.MemAddr !== 32'h40) begin miscompares++; $display("FAIL fetch_addr: got %0h want 40", bus.MemAddr); end
        vectors++; if (bus.ArbState !== 2'd1) begin miscompares++; $display("FAIL fetch_state: got %0d want 1", bus.ArbState); end
        tick();
        vectors++; if (bus.MemReq !== 1'b1 || bus.IDone !== 1'b0) begin miscompares++; $display("FAIL fetch_wait: req/done got %0h/%0h want 1/0", bus.MemReq, bus.IDone); end
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h8C22_0004;
        tick();
        vectors++; if (bus.IDone !== 1'b1) begin miscompares++; $display("FAIL fetch_done: got %0h want 1", bus.IDone); end
        vectors++; if (bus.IRData !== 32'h8C22_0004) begin miscompares++; $display("FAIL fetch_rdata: got %0h want 8c220004", bus.IRData); end
        vectors++; if (bus.ArbState !== 2'd0 || bus.MemReq !== 1'b0) begin miscompares++; $display("FAIL fetch_release: state/req got %0d/%0h want 0/0", bus.ArbState, bus.MemReq); end
        bus.IReq     = 1'b0;
        bus.MemReady = 1'b0;
        tick();
        vectors++; if (bus.IDone !== 1'b0) begin miscompares++; $display("FAIL fetch_done_pulse: got %0h want 0", bus.IDone); end
        $display("txn fetch addr=40 data=%h", bus.IRData);
    endtask

    task automatic test_priority();
        bus.IReq     = 1'b1;
        bus.IAddr    = 32'h44;
        bus.DReq     = 1'b1;
        bus.DWe      = 1'b1;
        bus.DAddr    = 32'h1000;
        bus.DWData   = 32'hDEAD_BEEF;
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h0BAD_F00D;
        tick();
        vectors++; if (bus.ArbState !== 2'd2) begin miscompares++; $display("FAIL prio_state: got %0d want 2", bus.ArbState); end
        vectors++; if (bus.MemWe !== 1'b1 || bus.MemAddr !== 32'h1000 || bus.MemWData !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL prio_store: we/addr/wdata got %0h/%0h/%0h want 1/1000/deadbeef", bus.MemWe, bus.MemAddr, bus.MemWData); end
        tick();
        vectors++; if (bus.DDone !== 1'b1) begin miscompares++; $display("FAIL prio_ddone: got %0h want 1", bus.DDone); end
        vectors++; if (bus.DRData !== 32'h0) begin miscompares++; $display("FAIL prio_store_rdata: got %0h want 0", bus.DRData); end
        bus.DReq = 1'b0;
        tick();
        vectors++; if (bus.ArbState !== 2'd1 || bus.MemAddr !== 32'h44 || bus.MemWe !== 1'b0) begin miscompares++; $display("FAIL prio_fetch: state/addr/we got %0d/%0h/%0h want 1/44/0", bus.ArbState, bus.MemAddr, bus.MemWe); end
        vectors++; if (bus.MemWData !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL prio_wdata_held: got %0h want deadbeef", bus.MemWData); end
        tick();
        vectors++; if (bus.IDone !== 1'b1 || bus.IRData !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL prio_fetch_done: done/data got %0h/%0h want 1/badf00d", bus.IDone, bus.IRData); end
        bus.IReq     = 1'b0;
        bus.MemReady = 1'b0;
        tick();
        $display("txn priority store 1000 then fetch 44");
    endtask

    // Tie rounds: fetch withdraws while losing, so the starvation count climbs
    // to MAXW; the round after that must go to fetch, and then data again.
    task automatic test_starvation();
        for (int k = 0; k <= MAXW + 1; k++) begin
            logic want_i;
            want_i = (k == MAXW);
            bus.IReq     = 1'b1;
            bus.IAddr    = 32'h100 + 32'(k * 4);
            bus.DReq     = 1'b1;
            bus.DWe      = 1'b1;
            bus.DAddr    = 32'h2000 + 32'(k * 4);
            bus.DWData   = 32'(k);
            bus.MemReady = 1'b0;
            tick();
            vectors++; if (bus.ArbState !== (want_i ? 2'd1 : 2'd2)) begin miscompares++; $display("FAIL starve_round%0d: state got %0d want %0d", k, bus.ArbState, want_i ? 1 : 2); end
            if (want_i) begin
                bus.MemReady = 1'b1;
                tick();
                bus.IReq = 1'b0;
                tick();
                vectors++; if (bus.ArbState !== 2'd2 || bus.MemAddr !== bus.DAddr) begin miscompares++; $display("FAIL starve_after_fetch: state/addr got %0d/%0h want 2/%0h", bus.ArbState, bus.MemAddr, bus.DAddr); end
                tick();
            end else begin
                bus.IReq     = 1'b0;
                bus.MemReady = 1'b1;
                tick();
            end
            vectors++; if (bus.DDone !== 1'b1) begin miscompares++; $display("FAIL starve_ddone%0d: got %0h want 1", k, bus.DDone); end
            bus.DReq     = 1'b0;
            bus.MemReady = 1'b0;
            tick();
            $display("txn starvation round %0d winner %s", k, want_i ? "I" : "D");
        end
    endtask

    task automatic test_hold_in_done();
        int req_cycles;
        req_cycles   = 0;
        bus.IReq     = 1'b1;
        bus.IAddr    = 32'h80;
        bus.MemReady = 1'b1;
        tick();
        req_cycles += int'(bus.MemReq);
        tick();
        vectors++; if (bus.IDone !== 1'b1) begin miscompares++; $display("FAIL hold_idone: got %0h want 1", bus.IDone); end
        tick();
        req_cycles += int'(bus.MemReq);
        vectors++; if (bus.ArbState !== 2'd0 || bus.MemReq !== 1'b0) begin miscompares++; $display("FAIL hold_no_regrant: state/req got %0d/%0h want 0/0", bus.ArbState, bus.MemReq); end
        bus.IReq = 1'b0;
        tick();
        req_cycles += int'(bus.MemReq);
        vectors++; if (req_cycles != 1 || bus.ArbState !== 2'd0) begin miscompares++; $display("FAIL hold_single_txn: req cycles/state got %0d/%0d want 1/0", req_cycles, bus.ArbState); end
        bus.MemReady = 1'b0;
        $display("txn held fetch 80 served once");
    endtask

    task automatic test_drop_req();
        bus.DReq     = 1'b1;
        bus.DWe      = 1'b0;
        bus.DAddr    = 32'h3000;
        bus.MemReady = 1'b0;
        tick();
        vectors++; if (bus.ArbState !== 2'd2 || bus.MemWe !== 1'b0) begin miscompares++; $display("FAIL drop_grant: state/we got %0d/%0h want 2/0", bus.ArbState, bus.MemWe); end
        bus.DReq = 1'b0;
        tick();
        tick();
        vectors++; if (bus.MemReq !== 1'b1 || bus.DDone !== 1'b0) begin miscompares++; $display("FAIL drop_wait: req/done got %0h/%0h want 1/0", bus.MemReq, bus.DDone); end
        bus.MemReady = 1'b1;
        bus.MemRData = 32'h1234_5678;
        tick();
        vectors++; if (bus.DDone !== 1'b1 || bus.DRData !== 32'h1234_5678) begin miscompares++; $display("FAIL drop_done: done/data got %0h/%0h want 1/12345678", bus.DDone, bus.DRData); end
        bus.MemReady = 1'b0;
        tick();
        vectors++; if (bus.DDone !== 1'b0 || bus.DRData !== 32'h1234_5678) begin miscompares++; $display("FAIL drop_after: done/data got %0h/%0h want 0/12345678", bus.DDone, bus.DRData); end
        $display("txn load 3000 data=%h after req dropped", bus.DRData);
    endtask

    task automatic test_reset_midaccess();
        bus.DReq     = 1'b1;
        bus.DWe      = 1'b0;
        bus.DAddr    = 32'h4000;
        bus.MemReady = 1'b0;
        tick();
        vectors++; if (bus.ArbState !== 2'd2) begin miscompares++; $display("FAIL rstmid_grant: state got %0d want 2", bus.ArbState); end
        reset = 1'b1;
        tick();
        vectors++; if (bus.MemReq !== 1'b0 || bus.ArbState !== 2'd0) begin miscompares++; $display("FAIL rstmid_abort: req/state got %0h/%0d want 0/0", bus.MemReq, bus.ArbState); end
        vectors++; if (bus.DDone !== 1'b0 || bus.DRData !== 32'h0 || bus.MemAddr !== 32'h0) begin miscompares++; $display("FAIL rstmid_clear: done/rdata/addr got %0h/%0h/%0h want 0/0/0", bus.DDone, bus.DRData, bus.MemAddr); end
        reset        = 1'b0;
        bus.DReq     = 1'b0;
        bus.MemReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++; if (bus.DDone !== 1'b0 || bus.MemReq !== 1'b0) begin miscompares++; $display("FAIL rstmid_quiet%0d: done/req got %0h/%0h want 0/0", c, bus.DDone, bus.MemReq); end
        end
        bus.MemReady = 1'b0;
        $display("txn load 4000 abandoned by reset");
    endtask

    // Randomized traffic. The reference model follows the arbitration rules
    // at transaction level: one access owns the port from grant to MemReady.
    task automatic test_random();
        bit          m_busy, m_owner_d, m_we, m_idone, m_ddone;
        logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
        int          m_cnt, n_i, n_d;
        logic [1:0]  exp_state;

        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
        m_busy = 0; m_owner_d = 0; m_we = 0; m_idone = 0; m_ddone = 0;
        m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
        m_cnt = 0; n_i = 0; n_d = 0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            bit ie, de;
            // Fetch requester: holds until Done, occasionally withdraws early.
            if (bus.IReq) begin
                if (m_idone) begin
                    bus.IReq = 1'($urandom_range(0, 1));
                end else if (!(m_busy && !m_owner_d) && $urandom_range(0, 11) == 0) begin
                    bus.IReq = 1'b0;
                end else if (m_busy && !m_owner_d && $urandom_range(0, 7) == 0) begin
                    bus.IReq = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                bus.IReq = 1'b1;
            end
            // Data requester: busier, so ties and starvation occur often.
            if (bus.DReq) begin
                if (m_ddone) begin
                    bus.DReq = 1'($urandom_range(0, 1));
                end else if (m_busy && m_owner_d && $urandom_range(0, 7) == 0) begin
                    bus.DReq = 1'b0;
                end
            end else if ($urandom_range(0, 1) == 0) begin
                bus.DReq = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) bus.IAddr = $urandom;
            if ($urandom_range(0, 3) == 0) bus.DAddr = $urandom;
            if ($urandom_range(0, 3) == 0) bus.DWData = $urandom;
            if ($urandom_range(0, 3) == 0) bus.DWe = 1'($urandom_range(0, 1));
            bus.MemReady = ($urandom_range(0, 2) != 0);
            bus.MemRData = $urandom;

            // Model: what the next edge must produce.
            ie = bus.IReq && !m_idone;
            de = bus.DReq && !m_ddone;
            if (!m_busy) begin
                if (ie && (!de || m_cnt == MAXW)) begin
                    m_busy = 1; m_owner_d = 0; m_we = 0; m_addr = bus.IAddr; m_cnt = 0; n_i++;
                end else if (de) begin
                    m_busy = 1; m_owner_d = 1; m_we = bus.DWe; m_addr = bus.DAddr; m_wdata = bus.DWData; n_d++;
                    if (ie && m_cnt < MAXW) m_cnt++;
                end
                m_idone = 0;
                m_ddone = 0;
            end else if (bus.MemReady) begin
                m_idone = !m_owner_d;
                m_ddone = m_owner_d;
                if (!m_owner_d) m_irdata = bus.MemRData;
                else if (!m_we) m_drdata = bus.MemRData;
                m_busy = 0;
                m_we   = 0;
            end else begin
                m_idone = 0;
                m_ddone = 0;
            end

            tick();

            exp_state = !m_busy ? 2'd0 : (m_owner_d ? 2'd2 : 2'd1);
            vectors++; if (bus.ArbState !== exp_state) begin miscompares++; $display("FAIL rnd_state c%0d: got %0d want %0d", cyc, bus.ArbState, exp_state); end
            vectors++; if (bus.MemReq !== m_busy || bus.MemWe !== m_we) begin miscompares++; $display("FAIL rnd_reqwe c%0d: got %0h/%0h want %0h/%0h", cyc, bus.MemReq, bus.MemWe, m_busy, m_we); end
            vectors++; if (bus.MemAddr !== m_addr || bus.MemWData !== m_wdata) begin miscompares++; $display("FAIL rnd_membus c%0d: got %0h/%0h want %0h/%0h", cyc, bus.MemAddr, bus.MemWData, m_addr, m_wdata); end
            vectors++; if (bus.IDone !== m_idone || bus.DDone !== m_ddone) begin miscompares++; $display("FAIL rnd_done c%0d: got %0h/%0h want %0h/%0h", cyc, bus.IDone, bus.DDone, m_idone, m_ddone); end
            vectors++; if (bus.IRData !== m_irdata || bus.DRData !== m_drdata) begin miscompares++; $display("FAIL rnd_rdata c%0d: got %0h/%0h want %0h/%0h", cyc, bus.IRData, bus.DRData, m_irdata, m_drdata); end
            if (m_idone) $display("txn rnd fetch addr=%h data=%h", m_addr, m_irdata);
            if (m_ddone) $display("txn rnd data addr=%h we=%0d rdata=%h", m_addr, bus.DWe, m_drdata);
        end
        $display("txn random grants fetch=%0d data=%0d", n_i, n_d);
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_hold_in_done();
        test_drop_req();
        test_reset_midaccess();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
